// File: rtl/pong_pkg.sv
// Pong shared definitions: match states and datapath widths.
// Used by the match controller, ball logic and score overlay.
package pong_pkg;

    localparam int BCD_W = 8;
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

endpackage

// File: rtl/bcd_counter_2d.sv
// Two-digit packed-BCD counter with sync clear.
// Holds at 99 instead of wrapping.
import pong_pkg::*;

module bcd_counter_2d (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] q
);

    logic [3:0] tens;
    logic [3:0] ones;

    assign tens = q[7:4];
    assign ones = q[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && q != 8'h99) begin
            if (ones == 4'd9) begin
                q <= {tens + 4'd1, 4'd0};
            end else begin
                q <= {tens, ones + 4'd1};
            end
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Pong match controller: serve countdown, scoring and game-over.
// Ball control outputs are decoded straight from the state register.
import pong_pkg::*;

module score_keeper #(
    parameter logic [BCD_W-1:0] WIN_SCORE   = 8'h11,
    parameter int               SERVE_TICKS = 60
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             FRAME_TICK,
    input  logic             START,
    input  logic             GOAL_ONE,
    input  logic             GOAL_TWO,
    output logic [BCD_W-1:0] PLAYER_ONE,
    output logic [BCD_W-1:0] PLAYER_TWO,
    output logic             SERVE_DIR,
    output logic             BALL_HOLD,
    output logic             BALL_ENABLE,
    output logic             GAME_OVER,
    output logic             WINNER
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SERVE_TICKS - 1);

    state_t           state;
    state_t           state_nxt;
    logic             start_q;
    logic             start_edge;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             clr;
    logic             in_play;
    logic             inc_one;
    logic             inc_two;
    logic             win;

    assign start_edge = START & ~start_q;
    assign in_play    = (state == PLAY);
    assign inc_one    = in_play & GOAL_ONE & ~GOAL_TWO;
    assign inc_two    = in_play & GOAL_TWO & ~GOAL_ONE;

    // SERVE_DIR=1 means player one just scored
    assign win = SERVE_DIR ? (PLAYER_ONE == WIN_SCORE)
                           : (PLAYER_TWO == WIN_SCORE);

    // Reset high so a START held through reset is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b1;
        end else begin
            start_q <= START;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        clr       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_edge) begin
                    state_nxt = SERVE;
                    load      = 1'b1;
                    clr       = 1'b1;
                end
            end
            SERVE: begin
                if (FRAME_TICK && cnt == '0) begin
                    state_nxt = PLAY;
                end
            end
            PLAY: begin
                if (GOAL_ONE && GOAL_TWO) begin
                    state_nxt = SERVE;
                    load      = 1'b1;
                end else if (GOAL_ONE || GOAL_TWO) begin
                    state_nxt = POINT;
                end
            end
            POINT: begin
                if (win) begin
                    state_nxt = OVER;
                end else begin
                    state_nxt = SERVE;
                    load      = 1'b1;
                end
            end
            OVER: begin
                if (start_edge) begin
                    state_nxt = SERVE;
                    load      = 1'b1;
                    clr       = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        BALL_HOLD   = 1'b1;
        BALL_ENABLE = 1'b0;
        GAME_OVER   = 1'b0;
        unique case (state)
            PLAY: begin
                BALL_HOLD   = 1'b0;
                BALL_ENABLE = 1'b1;
            end
            OVER:    GAME_OVER = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_LOAD;
        end else if (state == SERVE && FRAME_TICK && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SERVE_DIR <= 1'b0;
        end else if (state == OVER && start_edge) begin
            SERVE_DIR <= 1'b0;
        end else if (inc_one) begin
            SERVE_DIR <= 1'b1;
        end else if (inc_two) begin
            SERVE_DIR <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WINNER <= 1'b0;
        end else if (state == POINT && win) begin
            WINNER <= ~SERVE_DIR;
        end
    end

    bcd_counter_2d u_p1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (inc_one),
        .q     (PLAYER_ONE)
    );

    bcd_counter_2d u_p2 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (inc_two),
        .q     (PLAYER_TWO)
    );

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with a 3-frame serve.
// Inputs driven and outputs sampled on the falling edge.
module tb_score_keeper;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       FRAME_TICK = 1'b0;
    logic       START = 1'b0;
    logic       GOAL_ONE = 1'b0;
    logic       GOAL_TWO = 1'b0;
    logic [7:0] PLAYER_ONE;
    logic [7:0] PLAYER_TWO;
    logic       SERVE_DIR;
    logic       BALL_HOLD;
    logic       BALL_ENABLE;
    logic       GAME_OVER;
    logic       WINNER;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    score_keeper #(
        .WIN_SCORE   (8'h11),
        .SERVE_TICKS (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .FRAME_TICK  (FRAME_TICK),
        .START       (START),
        .GOAL_ONE    (GOAL_ONE),
        .GOAL_TWO    (GOAL_TWO),
        .PLAYER_ONE  (PLAYER_ONE),
        .PLAYER_TWO  (PLAYER_TWO),
        .SERVE_DIR   (SERVE_DIR),
        .BALL_HOLD   (BALL_HOLD),
        .BALL_ENABLE (BALL_ENABLE),
        .GAME_OVER   (GAME_OVER),
        .WINNER      (WINNER)
    );

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame();
        FRAME_TICK = 1'b1;
        @(negedge clk);
        FRAME_TICK = 1'b0;
        @(negedge clk);
    endtask

    task automatic serve_to_play();
        repeat (3) frame();
    endtask

    task automatic goal(input logic g1, input logic g2);
        GOAL_ONE = g1;
        GOAL_TWO = g2;
        @(negedge clk);
        GOAL_ONE = 1'b0;
        GOAL_TWO = 1'b0;
    endtask

    task automatic press_start();
        START = 1'b1;
        @(negedge clk);
        START = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // 1: reset with START held, then release
        START = 1'b1;
        idle_cycles(3);
        rst_n = 1'b1;
        idle_cycles(3);
        START = 1'b0;
        idle_cycles(2);
        check("rst_p1", PLAYER_ONE, 8'h00);
        check("rst_p2", PLAYER_TWO, 8'h00);
        check("rst_dir", {7'd0, SERVE_DIR}, 8'd0);
        check("rst_hold", {7'd0, BALL_HOLD}, 8'd1);
        check("rst_en", {7'd0, BALL_ENABLE}, 8'd0);
        check("rst_over", {7'd0, GAME_OVER}, 8'd0);
        check("rst_win", {7'd0, WINNER}, 8'd0);
        serve_to_play();
        check("idle_no_serve", {7'd0, BALL_ENABLE}, 8'd0);

        // 2: start, three frames of hold
        press_start();
        frame();
        frame();
        idle_cycles(3);
        check("serve_2tick_en", {7'd0, BALL_ENABLE}, 8'd0);
        check("serve_2tick_hold", {7'd0, BALL_HOLD}, 8'd1);
        frame();
        check("play_en", {7'd0, BALL_ENABLE}, 8'd1);
        check("play_hold", {7'd0, BALL_HOLD}, 8'd0);

        // 3: player one scores
        goal(1'b1, 1'b0);
        check("g1_p1", PLAYER_ONE, 8'h01);
        check("g1_dir", {7'd0, SERVE_DIR}, 8'd1);
        check("point_hold", {7'd0, BALL_HOLD}, 8'd1);
        check("point_en", {7'd0, BALL_ENABLE}, 8'd0);
        @(negedge clk);
        check("point_over", {7'd0, GAME_OVER}, 8'd0);
        serve_to_play();
        check("reserve_en", {7'd0, BALL_ENABLE}, 8'd1);

        // 4: player two to 9, then carry to 10
        repeat (9) begin
            goal(1'b0, 1'b1);
            @(negedge clk);
            serve_to_play();
        end
        check("p2_09", PLAYER_TWO, 8'h09);
        check("g2_dir", {7'd0, SERVE_DIR}, 8'd0);
        goal(1'b0, 1'b1);
        check("p2_carry", PLAYER_TWO, 8'h10);
        check("p1_kept", PLAYER_ONE, 8'h01);
        @(negedge clk);
        serve_to_play();

        // 5: player one to 10, then the winning point
        repeat (9) begin
            goal(1'b1, 1'b0);
            @(negedge clk);
            serve_to_play();
        end
        check("p1_10", PLAYER_ONE, 8'h10);
        check("p1_10_en", {7'd0, BALL_ENABLE}, 8'd1);
        goal(1'b1, 1'b0);
        check("p1_11", PLAYER_ONE, 8'h11);
        check("over_n", {7'd0, GAME_OVER}, 8'd0);
        @(negedge clk);
        check("over_n1", {7'd0, GAME_OVER}, 8'd1);
        check("winner", {7'd0, WINNER}, 8'd0);
        check("over_hold", {7'd0, BALL_HOLD}, 8'd1);
        check("over_en", {7'd0, BALL_ENABLE}, 8'd0);
        goal(1'b1, 1'b0);
        goal(1'b0, 1'b1);
        serve_to_play();
        check("frozen_p1", PLAYER_ONE, 8'h11);
        check("frozen_p2", PLAYER_TWO, 8'h10);
        check("frozen_over", {7'd0, GAME_OVER}, 8'd1);
        press_start();
        check("restart_p1", PLAYER_ONE, 8'h00);
        check("restart_p2", PLAYER_TWO, 8'h00);
        check("restart_over", {7'd0, GAME_OVER}, 8'd0);
        check("restart_dir", {7'd0, SERVE_DIR}, 8'd0);

        // 6: simultaneous goals replay the serve
        serve_to_play();
        goal(1'b1, 1'b0);
        @(negedge clk);
        serve_to_play();
        goal(1'b1, 1'b1);
        check("both_p1", PLAYER_ONE, 8'h01);
        check("both_p2", PLAYER_TWO, 8'h00);
        check("both_dir", {7'd0, SERVE_DIR}, 8'd1);
        check("both_en", {7'd0, BALL_ENABLE}, 8'd0);
        frame();
        frame();
        check("replay_2tick", {7'd0, BALL_ENABLE}, 8'd0);
        frame();
        check("replay_play", {7'd0, BALL_ENABLE}, 8'd1);
        press_start();
        check("midrally_start", {7'd0, BALL_ENABLE}, 8'd1);
        check("midrally_p1", PLAYER_ONE, 8'h01);

        // 6b: async reset in the middle of a serve countdown
        goal(1'b0, 1'b1);
        @(negedge clk);
        frame();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_p2", PLAYER_TWO, 8'h00);
        check("async_dir", {7'd0, SERVE_DIR}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);
        frame();
        frame();
        check("post_rst_idle", {7'd0, BALL_ENABLE}, 8'd0);
        press_start();
        frame();
        frame();
        check("fresh_count", {7'd0, BALL_ENABLE}, 8'd0);
        frame();
        check("fresh_play", {7'd0, BALL_ENABLE}, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
